seg7_scan_decoder: RTL and testbench

//  Receive side of the 7-segment display path. Snoops a multiplexed, active-low 4-digit

---
 rtl/seg7_scan_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Recovers the hex frame shown on a scanned, active-low 4-digit 7-segment bus.
// Optional decimal-point capture is enabled by defining SEG7_DP_EN.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  dig_n,
`ifdef SEG7_DP_EN
  input  logic        dp_n,
  output logic [3:0]  dp,
`endif
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        pattern_err,
  output logic [3:0]  capt_mask
);

`ifdef SEG7_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif
  localparam int SMP_W = SEG_W + 4;
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HOLD} state_t;

  // {legal, index} for a one-hot-low strobe; anything else is "no digit"
  function automatic logic [2:0] strobe_decode(input logic [3:0] d);
    case (d)
      4'b1110: strobe_decode = 3'b1_00;
      4'b1101: strobe_decode = 3'b1_01;
      4'b1011: strobe_decode = 3'b1_10;
      4'b0111: strobe_decode = 3'b1_11;
      default: strobe_decode = 3'b0_00;
    endcase
  endfunction

  // {legal, nibble} for an active-low gfedcba pattern
  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    case (s)
      7'h40: glyph_decode = 5'h10;
      7'h79: glyph_decode = 5'h11;
      7'h24: glyph_decode = 5'h12;
      7'h30: glyph_decode = 5'h13;
      7'h19: glyph_decode = 5'h14;
      7'h12: glyph_decode = 5'h15;
      7'h02: glyph_decode = 5'h16;
      7'h78: glyph_decode = 5'h17;
      7'h00: glyph_decode = 5'h18;
      7'h10: glyph_decode = 5'h19;
      7'h08: glyph_decode = 5'h1A;
      7'h03: glyph_decode = 5'h1B;
      7'h46: glyph_decode = 5'h1C;
      7'h21: glyph_decode = 5'h1D;
      7'h06: glyph_decode = 5'h1E;
      7'h0E: glyph_decode = 5'h1F;
      default: glyph_decode = 5'h00;
    endcase
  endfunction

  logic [SEG_W-1:0] w_seg_in;
  logic [SEG_W-1:0] r_seg_s1, r_seg_s2;
  logic [3:0]       r_dig_s1, r_dig_s2;
  logic [SMP_W-1:0] w_smp, r_prev;
  logic             w_same, w_legal, w_glyph_ok, w_capture;
  logic [1:0]       w_idx;
  logic [3:0]       w_nib, w_mask_next;
  logic [15:0]      w_frame, r_slots, r_value;
  logic [3:0]       r_capt_mask;
  logic             r_frame_valid, r_perr;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;

`ifdef SEG7_DP_EN
  logic [3:0] r_dp_slots, r_dp, w_dp_frame;
  assign w_seg_in = {dp_n, seg_n};
  assign dp       = r_dp;
`else
  assign w_seg_in = seg_n;
`endif

  assign w_smp                 = {r_dig_s2, r_seg_s2};
  assign w_same                = (w_smp == r_prev);
  assign {w_legal, w_idx}      = strobe_decode(r_dig_s2);
  assign {w_glyph_ok, w_nib}   = glyph_decode(r_seg_s2[6:0]);
  assign w_mask_next           = r_capt_mask | (4'b0001 << w_idx);
  assign w_capture             = (r_state == ST_SETTLE) && w_same && (r_cnt == CNT_CAP);

  always_comb begin
    w_frame = r_slots;
    w_frame[{w_idx, 2'b00} +: 4] = w_nib;
  end

  // Two-flop synchronizers; idle bus reads as all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_dig_s1 <= '1;
      r_dig_s2 <= '1;
      r_prev   <= '1;
    end else begin
      r_seg_s1 <= w_seg_in;
      r_seg_s2 <= r_seg_s1;
      r_dig_s1 <= dig_n;
      r_dig_s2 <= r_dig_s1;
      r_prev   <= w_smp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_legal) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (w_same) begin
            if (r_cnt == CNT_CAP) begin
              r_cnt   <= CNT_LAST;
              r_state <= ST_HOLD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= w_legal ? ST_SETTLE : ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (!w_same) begin
            r_cnt   <= '0;
            r_state <= w_legal ? ST_SETTLE : ST_WAIT;
          end
        end
        default: begin
          r_state <= ST_WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Capture into digit slots; the frame-complete edge publishes value and clears the mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slots       <= '0;
      r_value       <= '0;
      r_capt_mask   <= '0;
      r_frame_valid <= 1'b0;
      r_perr        <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_perr        <= 1'b0;
      if (w_capture) begin
        if (!w_glyph_ok) begin
          r_perr <= 1'b1;
        end else begin
          r_slots <= w_frame;
          if (w_mask_next == 4'hF) begin
            r_value       <= w_frame;
            r_frame_valid <= 1'b1;
            r_capt_mask   <= '0;
          end else begin
            r_capt_mask <= w_mask_next;
          end
        end
      end
    end
  end

`ifdef SEG7_DP_EN
  always_comb begin
    w_dp_frame        = r_dp_slots;
    w_dp_frame[w_idx] = ~r_seg_s2[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_slots <= '0;
      r_dp       <= '0;
    end else if (w_capture && w_glyph_ok) begin
      r_dp_slots <= w_dp_frame;
      if (w_mask_next == 4'hF) r_dp <= w_dp_frame;
    end
  end
`endif

  assign value       = r_value;
  assign frame_valid = r_frame_valid;
  assign pattern_err = r_perr;
  assign capt_mask   = r_capt_mask;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: expected frames are queued as digits are scanned.
module tb_seg7_scan_decoder;
  localparam int STABLE = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic [15:0] value;
  logic        frame_valid, pattern_err;
  logic [3:0]  capt_mask;
  logic [3:0]  dp_act;

  int checks = 0;
  int errors = 0;
  int n_frames = 0;
  int n_perr = 0;

  logic [19:0] exp_q[$];
  logic [15:0] m_slots;
  logic [3:0]  m_mask, m_dp;

  always #5 clk = ~clk;

`ifdef SEG7_DP_EN
  logic dp_n;
  seg7_scan_decoder dut (.clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_n(dig_n),
                         .dp_n(dp_n), .dp(dp_act), .value(value), .frame_valid(frame_valid),
                         .pattern_err(pattern_err), .capt_mask(capt_mask));
`else
  seg7_scan_decoder dut (.clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_n(dig_n),
                         .value(value), .frame_valid(frame_valid),
                         .pattern_err(pattern_err), .capt_mask(capt_mask));
  assign dp_act = 4'h0;
`endif

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        n_frames++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected value=%h dp=%b required no frame", value, dp_act);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          if ({dp_act, value} !== e) begin
            errors++;
            $display("FAIL frame_value got dp=%b value=%h required dp=%b value=%h",
                     dp_act, value, e[19:16], e[15:0]);
          end
        end
      end
      if (pattern_err) n_perr++;
    end
  end

  function automatic logic [4:0] model_glyph(input logic [6:0] s);
    model_glyph = 5'h00;
    for (int k = 0; k < 16; k++) if (GLYPH[k] == s) model_glyph = {1'b1, 4'(k)};
  endfunction

  task automatic set_pins(input int idx, input logic [6:0] seg, input bit dpv);
    dig_n = (idx < 0) ? 4'hF : ~(4'b0001 << idx);
    seg_n = seg;
`ifdef SEG7_DP_EN
    dp_n = ~dpv;
`endif
  endtask

  task automatic idle(input int n);
    set_pins(-1, 7'h7F, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  // Model the capture at stimulus time, then hold the digit on the bus
  task automatic scan_digit(input int idx, input logic [6:0] seg, input bit dpv, input int hold);
    logic [4:0] g;
    logic [3:0] nm;
    g = model_glyph(seg);
    if (hold >= STABLE) begin
      if (g[4]) begin
        m_slots[idx*4 +: 4] = g[3:0];
        m_dp[idx] = dpv;
        nm = m_mask | (4'b0001 << idx);
        if (nm == 4'hF) begin
`ifdef SEG7_DP_EN
          exp_q.push_back({m_dp, m_slots});
`else
          exp_q.push_back({4'h0, m_slots});
`endif
          m_mask = 4'h0;
        end else begin
          m_mask = nm;
        end
      end
    end
    set_pins(idx, seg, dpv);
    repeat (hold) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_timeout pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    set_pins(-1, 7'h7F, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (value !== 16'h0)   begin errors++; $display("FAIL reset_value got %h required 0000", value); end
    if (frame_valid !== 0) begin errors++; $display("FAIL reset_fv got %b required 0", frame_valid); end
    if (pattern_err !== 0) begin errors++; $display("FAIL reset_perr got %b required 0", pattern_err); end
    if ({dp_act, capt_mask} !== 8'h0) begin
      errors++; $display("FAIL reset_mask got dp=%b mask=%b required 0/0", dp_act, capt_mask);
    end
    m_slots = '0; m_mask = '0; m_dp = '0;
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_frame();
    int f0;
    f0 = n_frames;
    scan_digit(0, 7'h30, 1'b0, 8);
    scan_digit(1, 7'h24, 1'b0, 8);
    scan_digit(2, 7'h79, 1'b0, 8);
    scan_digit(3, 7'h40, 1'b0, 8);
    idle(4);
    drain();
    checks += 3;
    if (n_frames != f0 + 1) begin errors++; $display("FAIL frame_count got %0d required %0d", n_frames - f0, 1); end
    if (value !== 16'h0123) begin errors++; $display("FAIL frame_basic got %h required 0123", value); end
    if (capt_mask !== 4'h0) begin errors++; $display("FAIL frame_mask_clear got %b required 0000", capt_mask); end
  endtask

  task automatic test_single_capture();
    int f0, lat;
    f0 = n_frames;
    lat = 0;
    m_slots[3:0] = 4'h5; m_mask = 4'b0001;
    set_pins(0, 7'h12, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (capt_mask[0] && lat == 0) lat = c;
      if (c == 5) set_pins(-1, 7'h7F, 1'b0);
    end
    checks += 4;
    if (lat != 2 + STABLE) begin errors++; $display("FAIL capture_latency got %0d required %0d", lat, 2 + STABLE); end
    if (capt_mask !== 4'b0001) begin errors++; $display("FAIL single_mask got %b required 0001", capt_mask); end
    if (n_frames != f0) begin errors++; $display("FAIL single_no_frame got %0d required 0", n_frames - f0); end
    if (value !== 16'h0123) begin errors++; $display("FAIL value_hold got %h required 0123", value); end
  endtask

  task automatic test_glitch();
    int p0, f0;
    p0 = n_perr; f0 = n_frames;
    for (int k = 0; k < 10; k++) begin
      set_pins(1, GLYPH[k % 4 + 6], 1'b0);
      repeat (2) @(negedge clk);
    end
    idle(6);
    checks += 3;
    if (capt_mask !== 4'b0001) begin errors++; $display("FAIL glitch_mask got %b required 0001", capt_mask); end
    if (n_perr != p0) begin errors++; $display("FAIL glitch_perr got %0d required 0", n_perr - p0); end
    if (n_frames != f0) begin errors++; $display("FAIL glitch_frame got %0d required 0", n_frames - f0); end
  endtask

  task automatic test_illegal();
    int p0;
    p0 = n_perr;
    scan_digit(2, 7'h7F, 1'b0, 8);
    idle(4);
    checks += 2;
    if (n_perr != p0 + 1) begin errors++; $display("FAIL illegal_perr got %0d required 1", n_perr - p0); end
    if (capt_mask !== 4'b0001) begin errors++; $display("FAIL illegal_mask got %b required 0001", capt_mask); end
    scan_digit(0, 7'h0E, 1'b0, 8);
    scan_digit(1, 7'h06, 1'b0, 8);
    scan_digit(2, 7'h21, 1'b0, 8);
    scan_digit(3, 7'h46, 1'b0, 8);
    idle(4);
    drain();
    checks += 2;
    if (value !== 16'hCDEF) begin errors++; $display("FAIL illegal_then_frame got %h required CDEF", value); end
    if (capt_mask !== 4'h0) begin errors++; $display("FAIL illegal_mask_clear got %b required 0000", capt_mask); end
  endtask

  task automatic test_double_strobe();
    int p0, f0;
    p0 = n_perr; f0 = n_frames;
    dig_n = 4'b1100;
    seg_n = 7'h40;
    repeat (20) @(negedge clk);
    idle(4);
    checks += 4;
    if (n_frames != f0) begin errors++; $display("FAIL double_frame got %0d required 0", n_frames - f0); end
    if (n_perr != p0)   begin errors++; $display("FAIL double_perr got %0d required 0", n_perr - p0); end
    if (capt_mask !== 4'h0) begin errors++; $display("FAIL double_mask got %b required 0000", capt_mask); end
    if (value !== 16'hCDEF) begin errors++; $display("FAIL double_value got %h required CDEF", value); end
  endtask

  task automatic test_reset_midframe();
    scan_digit(0, 7'h79, 1'b0, 8);
    scan_digit(1, 7'h24, 1'b0, 8);
    scan_digit(2, 7'h30, 1'b0, 8);
    checks++;
    if (capt_mask !== 4'b0111) begin errors++; $display("FAIL pre_reset_mask got %b required 0111", capt_mask); end
    set_pins(3, 7'h19, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (value !== 16'h0)   begin errors++; $display("FAIL midreset_value got %h required 0000", value); end
    if (frame_valid !== 0) begin errors++; $display("FAIL midreset_fv got %b required 0", frame_valid); end
    if (pattern_err !== 0) begin errors++; $display("FAIL midreset_perr got %b required 0", pattern_err); end
    if ({dp_act, capt_mask} !== 8'h0) begin
      errors++; $display("FAIL midreset_mask got dp=%b mask=%b required 0/0", dp_act, capt_mask);
    end
    m_slots = '0; m_mask = '0; m_dp = '0;
    exp_q.delete();
    @(negedge clk);
    set_pins(-1, 7'h7F, 1'b0);
    rst_n = 1'b1;
    idle(3);
    scan_digit(0, 7'h79, 1'b0, 8);
    scan_digit(1, 7'h24, 1'b1, 8);
    scan_digit(2, 7'h30, 1'b0, 8);
    scan_digit(3, 7'h19, 1'b0, 8);
    idle(4);
    drain();
    checks++;
    if (value !== 16'h4321) begin errors++; $display("FAIL post_reset_frame got %h required 4321", value); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_single_capture();
    test_glitch();
    test_illegal();
    test_double_strobe();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
